// File: rtl/ace_snoop_initiator.sv
// ACE snoop initiator: drives one snoop on AC, collects CR and CD,
// and returns a single consolidated line response upstream.
`timescale 1ns/1ps
module ace_snoop_initiator #(
   parameter int AddrWidth = 64,
   parameter int DataWidth = 64,
   parameter int LineWidth = 128
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 req_valid_i,
   output logic                 req_ready_o,
   input  logic [AddrWidth-1:0] req_addr_i,
   input  logic [3:0]           req_snoop_i,
   input  logic [2:0]           req_prot_i,
   output logic                 ac_valid_o,
   input  logic                 ac_ready_i,
   output logic [AddrWidth-1:0] ac_addr_o,
   output logic [3:0]           ac_snoop_o,
   output logic [2:0]           ac_prot_o,
   input  logic                 cr_valid_i,
   output logic                 cr_ready_o,
   input  logic [4:0]           cr_resp_i,
   input  logic                 cd_valid_i,
   output logic                 cd_ready_o,
   input  logic [DataWidth-1:0] cd_data_i,
   input  logic                 cd_last_i,
   output logic                 rsp_valid_o,
   input  logic                 rsp_ready_i,
   output logic [LineWidth-1:0] rsp_data_o,
   output logic                 rsp_has_data_o,
   output logic                 rsp_dirty_o,
   output logic                 rsp_shared_o,
   output logic                 rsp_error_o,
   output logic                 busy_o
);

   localparam int Beats = LineWidth / DataWidth;
   localparam int CntW  = (Beats > 1) ? $clog2(Beats) : 1;
   localparam int OffW  = $clog2(LineWidth / 8);

   localparam logic [CntW-1:0]      LastCnt   = CntW'(Beats - 1);
   localparam logic [AddrWidth-1:0] AlignMask =
      ~((AddrWidth'(1) << OffW) - AddrWidth'(1));

   typedef enum logic [2:0] {
      S_IDLE,
      S_AC,
      S_CR,
      S_CD,
      S_RSP
   } state_e;

   state_e state_q, state_d;

   logic [AddrWidth-1:0] addr_q, addr_d;
   logic [3:0]           snoop_q, snoop_d;
   logic [2:0]           prot_q, prot_d;
   logic [LineWidth-1:0] line_q, line_d;
   logic [CntW-1:0]      cnt_q, cnt_d;
   logic                 has_data_q, has_data_d;
   logic                 dirty_q, dirty_d;
   logic                 shared_q, shared_d;
   logic                 err_q, err_d;

   logic req_hs, ac_hs, cr_hs, cd_hs, rsp_hs;
   logic cd_at_last, cd_done;
   logic unused_was_unique;

   assign unused_was_unique = cr_resp_i[4];

   assign req_hs = (state_q == S_IDLE) && req_valid_i;
   assign ac_hs  = (state_q == S_AC)   && ac_ready_i;
   assign cr_hs  = (state_q == S_CR)   && cr_valid_i;
   assign cd_hs  = (state_q == S_CD)   && cd_valid_i;
   assign rsp_hs = (state_q == S_RSP)  && rsp_ready_i;

   assign cd_at_last = (cnt_q == LastCnt);
   assign cd_done    = cd_hs && (cd_last_i || cd_at_last);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: if (req_hs) state_d = S_AC;
         S_AC:   if (ac_hs) state_d = S_CR;
         S_CR: begin
            if (cr_hs) begin
               if (cr_resp_i[0] && !cr_resp_i[1]) state_d = S_CD;
               else                               state_d = S_RSP;
            end
         end
         S_CD:   if (cd_done) state_d = S_RSP;
         S_RSP:  if (rsp_hs) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      req_ready_o    = 1'b0;
      ac_valid_o     = 1'b0;
      cr_ready_o     = 1'b0;
      cd_ready_o     = 1'b0;
      rsp_valid_o    = 1'b0;
      busy_o         = 1'b1;
      ac_addr_o      = '0;
      ac_snoop_o     = '0;
      ac_prot_o      = '0;
      rsp_data_o     = '0;
      rsp_has_data_o = 1'b0;
      rsp_dirty_o    = 1'b0;
      rsp_shared_o   = 1'b0;
      rsp_error_o    = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            // Keep the command port closed while reset is held.
            req_ready_o = !rst_i;
            busy_o      = 1'b0;
         end
         S_AC: begin
            ac_valid_o = 1'b1;
            ac_addr_o  = addr_q;
            ac_snoop_o = snoop_q;
            ac_prot_o  = prot_q;
         end
         S_CR: cr_ready_o = 1'b1;
         S_CD: cd_ready_o = 1'b1;
         S_RSP: begin
            rsp_valid_o    = 1'b1;
            rsp_data_o     = line_q;
            rsp_has_data_o = has_data_q;
            rsp_dirty_o    = dirty_q;
            rsp_shared_o   = shared_q;
            rsp_error_o    = err_q;
         end
         default: busy_o = 1'b1;
      endcase
   end

   always_comb begin
      addr_d     = addr_q;
      snoop_d    = snoop_q;
      prot_d     = prot_q;
      line_d     = line_q;
      cnt_d      = cnt_q;
      has_data_d = has_data_q;
      dirty_d    = dirty_q;
      shared_d   = shared_q;
      err_d      = err_q;
      if (req_hs) begin
         addr_d  = req_addr_i & AlignMask;
         snoop_d = req_snoop_i;
         prot_d  = req_prot_i;
      end
      if (cr_hs) begin
         has_data_d = cr_resp_i[0];
         err_d      = cr_resp_i[1];
         dirty_d    = cr_resp_i[2];
         shared_d   = cr_resp_i[3];
         cnt_d      = '0;
      end
      if (cd_hs) begin
         for (int b = 0; b < Beats; b++) begin
            if (cnt_q == CntW'(b)) line_d[b*DataWidth +: DataWidth] = cd_data_i;
         end
         cnt_d = cnt_q + CntW'(1);
         // Framing error: last flag early, or missing on the final beat.
         if (cd_last_i != cd_at_last) err_d = 1'b1;
      end
      if (rsp_hs) begin
         line_d     = '0;
         cnt_d      = '0;
         has_data_d = 1'b0;
         dirty_d    = 1'b0;
         shared_d   = 1'b0;
         err_d      = 1'b0;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         addr_q     <= '0;
         snoop_q    <= '0;
         prot_q     <= '0;
         line_q     <= '0;
         cnt_q      <= '0;
         has_data_q <= 1'b0;
         dirty_q    <= 1'b0;
         shared_q   <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         addr_q     <= addr_d;
         snoop_q    <= snoop_d;
         prot_q     <= prot_d;
         line_q     <= line_d;
         cnt_q      <= cnt_d;
         has_data_q <= has_data_d;
         dirty_q    <= dirty_d;
         shared_q   <= shared_d;
         err_q      <= err_d;
      end
   end

endmodule

// File: tb/tb_ace_snoop_initiator.sv
// Randomized bench for ace_snoop_initiator against a transaction-level
// reference model; directed cases first, then random snoops.
`timescale 1ns/1ps
module tb_ace_snoop_initiator;

   localparam int AW = 64;
   localparam int DW = 64;
   localparam int LW = 128;
   localparam int NB = LW / DW;
   localparam int LB = LW / 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          req_valid, req_ready;
   logic [AW-1:0] req_addr;
   logic [3:0]    req_snoop;
   logic [2:0]    req_prot;
   logic          ac_valid, ac_ready;
   logic [AW-1:0] ac_addr;
   logic [3:0]    ac_snoop;
   logic [2:0]    ac_prot;
   logic          cr_valid, cr_ready;
   logic [4:0]    cr_resp;
   logic          cd_valid, cd_ready;
   logic [DW-1:0] cd_data;
   logic          cd_last;
   logic          rsp_valid, rsp_ready;
   logic [LW-1:0] rsp_data;
   logic          rsp_has_data, rsp_dirty, rsp_shared, rsp_error;
   logic          busy;

   int n_chk = 0;
   int n_err = 0;

   logic [DW-1:0] bd [NB];

   always #5 clk = ~clk;

   ace_snoop_initiator #(
      .AddrWidth(AW), .DataWidth(DW), .LineWidth(LW)
   ) dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .req_valid_i    (req_valid),
      .req_ready_o    (req_ready),
      .req_addr_i     (req_addr),
      .req_snoop_i    (req_snoop),
      .req_prot_i     (req_prot),
      .ac_valid_o     (ac_valid),
      .ac_ready_i     (ac_ready),
      .ac_addr_o      (ac_addr),
      .ac_snoop_o     (ac_snoop),
      .ac_prot_o      (ac_prot),
      .cr_valid_i     (cr_valid),
      .cr_ready_o     (cr_ready),
      .cr_resp_i      (cr_resp),
      .cd_valid_i     (cd_valid),
      .cd_ready_o     (cd_ready),
      .cd_data_i      (cd_data),
      .cd_last_i      (cd_last),
      .rsp_valid_o    (rsp_valid),
      .rsp_ready_i    (rsp_ready),
      .rsp_data_o     (rsp_data),
      .rsp_has_data_o (rsp_has_data),
      .rsp_dirty_o    (rsp_dirty),
      .rsp_shared_o   (rsp_shared),
      .rsp_error_o    (rsp_error),
      .busy_o         (busy)
   );

   task automatic chk(input string tag, input logic [LW-1:0] got,
                      input logic [LW-1:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_ctl"}, {req_ready, ac_valid, cr_ready, cd_ready,
          rsp_valid, busy, rsp_has_data, rsp_dirty, rsp_shared,
          rsp_error}, '0);
      chk({tag, "_ac"}, {ac_addr, ac_snoop, ac_prot}, '0);
      chk({tag, "_data"}, rsp_data, '0);
   endtask

   // last_pos >= NB means the cache never raises cd_last.
   task automatic run_txn(input logic [AW-1:0] addr, input logic [3:0] snp,
                          input logic [2:0] prot, input int ac_dly,
                          input logic [4:0] cr, input int last_pos,
                          input int rsp_dly, input bit abort);
      int            cyc;
      int            nb;
      logic [LW-1:0] eline;
      logic          eerr;
      logic [AW-1:0] ealign;
      ealign = addr - (addr % LB);
      eline  = '0;
      eerr   = cr[1];
      nb     = 0;
      @(negedge clk);
      chk("idle_req_ready", req_ready, 1);
      chk("idle_busy", busy, 0);
      req_valid = 1'b1;
      req_addr  = addr;
      req_snoop = snp;
      req_prot  = prot;
      @(negedge clk);
      cyc       = 1;
      req_valid = 1'b0;
      req_addr  = {$urandom, $urandom};
      req_snoop = 4'($urandom);
      req_prot  = 3'($urandom);
      for (int d = 0; d <= ac_dly; d++) begin
         chk("ac_valid", ac_valid, 1);
         chk("ac_addr", ac_addr, ealign);
         chk("ac_snoop", ac_snoop, snp);
         chk("ac_prot", ac_prot, prot);
         chk("ac_cr_ready", cr_ready, 0);
         chk("ac_cd_ready", cd_ready, 0);
         cd_valid = 1'($urandom);
         ac_ready = (d == ac_dly);
         @(negedge clk);
         cyc++;
      end
      ac_ready = 1'b0;
      cd_valid = 1'b0;
      chk("cr_ready", cr_ready, 1);
      chk("cr_cd_ready", cd_ready, 0);
      chk("cr_ac_valid", ac_valid, 0);
      cr_valid = 1'b1;
      cr_resp  = cr;
      @(negedge clk);
      cyc++;
      cr_valid = 1'b0;
      cr_resp  = 5'($urandom);
      if (cr[0] && !cr[1]) begin
         for (int i = 0; i < NB; i++) begin
            chk("cd_ready", cd_ready, 1);
            cd_valid = 1'b1;
            cd_data  = bd[i];
            cd_last  = (i == last_pos);
            eline[i*DW +: DW] = bd[i];
            nb++;
            @(negedge clk);
            cyc++;
            cd_valid = 1'b0;
            cd_last  = 1'b0;
            if (abort) begin
               rst = 1'b1;
               #1;
               chk_all_zero("abort");
               @(negedge clk);
               rst = 1'b0;
               return;
            end
            if (i == last_pos) break;
         end
         if (last_pos != NB - 1) eerr = 1'b1;
      end
      // Offer stray CD traffic during the response; it must be refused.
      cd_valid = 1'b1;
      cd_data  = {$urandom, $urandom};
      cd_last  = 1'b1;
      chk("rsp_latency", LW'(rsp_valid ? cyc : -1), LW'(3 + ac_dly + nb));
      for (int k = 0; k <= rsp_dly; k++) begin
         chk("rsp_valid", rsp_valid, 1);
         chk("rsp_data", rsp_data, eline);
         chk("rsp_has_data", rsp_has_data, cr[0]);
         chk("rsp_dirty", rsp_dirty, cr[2]);
         chk("rsp_shared", rsp_shared, cr[3]);
         chk("rsp_error", rsp_error, eerr);
         chk("rsp_cd_ready", cd_ready, 0);
         rsp_ready = (k == rsp_dly);
         @(negedge clk);
      end
      rsp_ready = 1'b0;
      cd_valid  = 1'b0;
      cd_last   = 1'b0;
      chk("post_rsp_valid", rsp_valid, 0);
      chk("post_busy", busy, 0);
      chk("post_req_ready", req_ready, 1);
   endtask

   initial begin
      rst       = 1'b1;
      req_valid = 1'b0;
      req_addr  = '0;
      req_snoop = '0;
      req_prot  = '0;
      ac_ready  = 1'b0;
      cr_valid  = 1'b0;
      cr_resp   = '0;
      cd_valid  = 1'b0;
      cd_data   = '0;
      cd_last   = 1'b0;
      rsp_ready = 1'b0;
      #1;
      chk_all_zero("reset");
      repeat (2) @(negedge clk);
      rst = 1'b0;

      bd[0] = 64'h1111_1111_1111_1111;
      bd[1] = 64'h2222_2222_2222_2222;
      run_txn(64'h8000_0048, 4'b0001, 3'b010, 0, 5'b01001, 1, 0, 1'b0);
      run_txn(64'h8000_1234, 4'b1101, 3'b000, 0, 5'b00000, 1, 1, 1'b0);
      run_txn(64'h0000_0000_dead_beef, 4'b0111, 3'b101, 4, 5'b00101, 1, 0,
              1'b0);
      bd[0] = 64'hcafe_f00d_0bad_beef;
      bd[1] = 64'h5555_aaaa_5555_aaaa;
      run_txn(64'h4000_0010, 4'b0001, 3'b001, 0, 5'b00001, 0, 0, 1'b0);
      run_txn(64'h4000_0020, 4'b0001, 3'b001, 1, 5'b00001, NB, 0, 1'b0);
      run_txn(64'h4000_0030, 4'b0010, 3'b011, 0, 5'b00011, 1, 2, 1'b0);
      run_txn(64'h4000_0040, 4'b0001, 3'b000, 0, 5'b00001, 1, 0, 1'b1);
      bd[0] = 64'h0123_4567_89ab_cdef;
      bd[1] = 64'hfedc_ba98_7654_3210;
      run_txn(64'h4000_004f, 4'b0001, 3'b000, 2, 5'b01101, 1, 0, 1'b0);

      for (int n = 0; n < 200; n++) begin
         int lp;
         for (int i = 0; i < NB; i++) bd[i] = {$urandom, $urandom};
         lp = ($urandom_range(0, 9) < 7) ? NB - 1 : $urandom_range(0, NB);
         run_txn({$urandom, $urandom}, 4'($urandom), 3'($urandom),
                 $urandom_range(0, 3), 5'($urandom), lp,
                 $urandom_range(0, 2), ($urandom_range(0, 19) == 0));
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/ace_snoop_initiator.md
# ace_snoop_initiator

Interconnect-side initiator for the ACE snoop channels (AC/CR/CD) that the data cache answers on its snoop port. It accepts one snoop command at a time from the coherency controller and drives it onto AC. It collects the CR response and, if data is transferred, the CD beats of the cache line. It then returns one consolidated response (line data plus dirty/shared/error flags) upstream. It sits between the CCU snoop arbiter and one cache's snoop port.

## Interface

Parameters:
- AddrWidth, 64, snoop address width
- DataWidth, 64, CD beat width
- LineWidth, 128, cache line width; must be a power-of-two multiple of DataWidth; Beats = LineWidth/DataWidth

Ports:
- clk_i  in  1  clock, all logic on rising edge
- rst_i  in  1  reset, asynchronous, active-high
- req_valid_i  in  1  snoop command valid
- req_ready_o  out  1  command accepted
- req_addr_i  in  AddrWidth  snoop address
- req_snoop_i  in  4  ACSNOOP code
- req_prot_i  in  3  ACPROT
- ac_valid_o  out  1  AC valid
- ac_ready_i  in  1  AC ready
- ac_addr_o  out  AddrWidth  AC address, line aligned
- ac_snoop_o  out  4  AC snoop code
- ac_prot_o  out  3  AC prot
- cr_valid_i  in  1  CR valid
- cr_ready_o  out  1  CR ready
- cr_resp_i  in  5  CRRESP: [0] DataTransfer, [1] Error, [2] PassDirty, [3] IsShared, [4] WasUnique
- cd_valid_i  in  1  CD valid
- cd_ready_o  out  1  CD ready
- cd_data_i  in  DataWidth  CD beat
- cd_last_i  in  1  CD last beat
- rsp_valid_o  out  1  consolidated response valid
- rsp_ready_i  in  1  response accepted
- rsp_data_o  out  LineWidth  assembled line; zero when no data was transferred
- rsp_has_data_o  out  1  CR DataTransfer was set
- rsp_dirty_o  out  1  PassDirty
- rsp_shared_o  out  1  IsShared
- rsp_error_o  out  1  CR Error or CD framing error
- busy_o  out  1  state != IDLE

## Operation

- FSM states: IDLE, AC, CR, CD, RSP.
- IDLE: req_ready_o=1. On req_valid_i, register the command and go to AC.
- Address registration: ac_addr_o is req_addr_i with the low log2(LineWidth/8) bits cleared.
- AC: ac_valid_o=1 with stable addr/snoop/prot until ac_ready_i. On the handshake, go to CR.
- CR: cr_ready_o=1. On cr_valid_i, register the flags.
  - If DataTransfer=1 and Error=0, go to CD with the beat counter at 0.
  - Otherwise go to RSP with rsp_data_o=0.
- CD: cd_ready_o=1. Each handshake writes cd_data_i into line bits [cnt*DataWidth +: DataWidth] and increments cnt.
  - Beat Beats-1 with cd_last_i=1: go to RSP.
  - cd_last_i=1 before beat Beats-1: set the error flag and go to RSP. Beats not received stay 0.
  - Beat Beats-1 with cd_last_i=0: set the error flag and go to RSP.
- RSP: rsp_valid_o=1 with all rsp_* outputs stable until rsp_ready_i. On the handshake, go to IDLE and clear the line register and flags.
- cd_ready_o=0 outside CD. cr_ready_o=0 outside CR. CD traffic outside CD is not accepted.
- Only one snoop is outstanding at any time; there is no queuing.

## Timing

- Reset: all outputs 0, state IDLE, line register, counter and flags 0. Reset mid-transaction aborts the transaction immediately; nothing is replayed.
- Command accepted at cycle t. Then:
  - ac_valid_o rises at t+1.
  - With ac_ready_i at t+1, cr_ready_o is high from t+2.
  - With cr_valid_i at t+2 and no data, rsp_valid_o is high at t+3.
  - With data, one beat per cycle, rsp_valid_o is high at t+3+Beats.
- req_ready_o is combinational on state only and does not depend on req_valid_i.
- Inputs may arrive in the same cycle that the corresponding ready rises. There is no combinational path from any *_valid_i to any *_ready_o.
- Back-to-back operation: the cycle after the RSP handshake is IDLE, so the next command is accepted one cycle after rsp_ready_i.

## Test plan

- ReadShared, addr 0x8000_0048, ac_ready_i at once, CR=5'b01001, CD beats 0x1111…, 0x2222… with last on beat 1:
  - ac_addr_o=0x8000_0040.
  - rsp_data_o={0x2222…,0x1111…}, shared=1, has_data=1, dirty=0, error=0.
  - rsp_valid_o high 5 cycles after acceptance.
- MakeInvalid, CR=0: rsp_valid_o high 3 cycles after acceptance, rsp_data_o=0, all flags 0.
- AC backpressure, ac_ready_i low for 4 cycles: ac_valid_o/addr/snoop held constant; cr_ready_o stays 0 until the handshake.
- Early cd_last_i on beat 0 with Beats=2: rsp_error_o=1, upper half of rsp_data_o = 0.
- CR with Error=1 and DataTransfer=1: no CD accepted (cd_ready_o stays 0), rsp_error_o=1.
- Reset asserted while in CD after 1 beat: all outputs 0 next edge; a following command completes normally with correct data.
